// File: rtl/axis_pkg.sv
// ---------------------------------------------------------------------------
// axis_pkg
// Shared definitions for the 8-bit AXI-Stream frame transmitter and its
// matching receiver.
//   AXIS_DATA_W / AXIS_LEN_W / AXIS_CNT_W : default data, frame-length and
//                                           frame-count widths
//   ST_IDLE / ST_SEND                     : one-bit FSM state encoding
//   hs()                                  : stream handshake (valid && ready)
// ---------------------------------------------------------------------------
package axis_pkg;

  localparam int AXIS_DATA_W = 8;
  localparam int AXIS_LEN_W  = 5;
  localparam int AXIS_CNT_W  = 5;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  // A beat transfers on a rising edge where both valid and ready are high.
  function automatic logic hs(input logic valid, input logic ready);
    return valid && ready;
  endfunction

endpackage

// File: rtl/axis_frame_counter.sv
// ---------------------------------------------------------------------------
// axis_frame_counter
// CNT_W-bit wrapping counter of completed frames.
//   clk    : rising-edge clock
//   reset  : synchronous active-high clear
//   inc    : count one completed frame this cycle (hs on the Tlast beat)
//   count  : registered count, wraps 2^CNT_W-1 -> 0
// ---------------------------------------------------------------------------
module axis_frame_counter
  import axis_pkg::*;
#(
  parameter int CNT_W = AXIS_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (inc) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/axis_8bit_frame_tx.sv
// ---------------------------------------------------------------------------
// axis_8bit_frame_tx
// AXI-Stream style frame source. On an accepted start it sends frame_len
// beats of an incrementing byte pattern starting at seed, with Tlast on the
// final beat, honouring T_ready backpressure and counting completed frames.
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   start       : one-cycle request to send a frame
//   frame_len   : beats in the frame (0 = request ignored), sampled on start
//   seed        : first byte of the frame, sampled on start
//   T_ready     : downstream ready
//   out_data    : stream data
//   T_valid_out : stream valid
//   Tlast       : final beat of a frame
//   busy        : frame in flight (state SEND)
//   frame_cnt   : completed frames, wrapping
// All outputs are registered; valid never depends combinationally on ready.
// ---------------------------------------------------------------------------
module axis_8bit_frame_tx
  import axis_pkg::*;
#(
  parameter int DATA_W = AXIS_DATA_W,
  parameter int LEN_W  = AXIS_LEN_W,
  parameter int CNT_W  = AXIS_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic [DATA_W-1:0] seed,
  input  logic              T_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              T_valid_out,
  output logic              Tlast,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt
);

  logic [0:0]        state_d,    state_q;
  logic [LEN_W-1:0]  len_d,      len_q;
  logic [LEN_W-1:0]  beat_idx_d, beat_idx_q;
  logic [DATA_W-1:0] data_d,     data_q;
  logic              valid_d,    valid_q;
  logic              last_d,     last_q;

  logic              hs_w;
  logic              load_w;
  logic              frame_done_w;
  logic [LEN_W-1:0]  beat_next_w;

  assign hs_w         = hs(valid_q, T_ready);
  assign load_w       = start && (frame_len != '0);
  assign frame_done_w = hs_w && last_q;
  assign beat_next_w  = beat_idx_q + LEN_W'(1);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    beat_idx_d = beat_idx_q;
    data_d     = data_q;
    valid_d    = valid_q;
    last_d     = last_q;

    case (state_q)
      ST_IDLE: begin
        if (load_w) begin
          len_d      = frame_len;
          data_d     = seed;
          valid_d    = 1'b1;
          last_d     = (frame_len == LEN_W'(1));
          beat_idx_d = LEN_W'(1);
          state_d    = ST_SEND;
        end
      end

      ST_SEND: begin
        // Without a handshake everything holds, so the beat on the bus
        // stays stable until the sink takes it.
        if (hs_w) begin
          if (last_q) begin
            // A start arriving with the final handshake chains the next
            // frame directly, leaving no idle cycle between frames.
            if (load_w) begin
              len_d      = frame_len;
              data_d     = seed;
              valid_d    = 1'b1;
              last_d     = (frame_len == LEN_W'(1));
              beat_idx_d = LEN_W'(1);
            end else begin
              valid_d = 1'b0;
              last_d  = 1'b0;
              state_d = ST_IDLE;
            end
          end else begin
            data_d     = data_q + DATA_W'(1);
            beat_idx_d = beat_next_w;
            last_d     = (beat_next_w == len_q);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      beat_idx_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      beat_idx_q <= beat_idx_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
    end
  end

  axis_frame_counter #(
    .CNT_W (CNT_W)
  ) u_frame_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (frame_done_w),
    .count (frame_cnt)
  );

  assign out_data    = data_q;
  assign T_valid_out = valid_q;
  assign Tlast       = last_q;
  assign busy        = (state_q == ST_SEND);

endmodule
